// File: rtl/scanline_buffer_if.sv
// Pixel-in / VGA-out bundle of the scanline ping-pong buffer.
interface scanline_buffer_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              in_valid;
    logic [7:0]        in_r;
    logic [7:0]        in_g;
    logic [7:0]        in_b;
    logic              line_swap;
    logic [ADDR_W-1:0] rd_x;
    logic              rd_visible;
    logic [7:0]        out_r;
    logic [7:0]        out_g;
    logic [7:0]        out_b;
    logic              out_valid;
    logic              underrun;
    logic              overflow;

    // Pixel source and VGA timing side.
    modport master (
        output in_valid, in_r, in_g, in_b, line_swap, rd_x, rd_visible,
        input  out_r, out_g, out_b, out_valid, underrun, overflow
    );

    // Line buffer side.
    modport slave (
        input  in_valid, in_r, in_g, in_b, line_swap, rd_x, rd_visible,
        output out_r, out_g, out_b, out_valid, underrun, overflow
    );
endinterface

// File: rtl/scanline_buffer.sv
// Ping-pong scanline buffer: one bank captures the incoming line while the
// other bank feeds the VGA pins, address-aligned to rd_x with 1-cycle latency.
module scanline_buffer #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned ADDR_W   = 10
) (
    input  logic            clk_25mhz,
    input  logic            rst,
    scanline_buffer_if.slave bus
);
    localparam int unsigned PIX_W = 24;
    localparam logic [ADDR_W-1:0] LINE_END = ADDR_W'(H_ACTIVE);

    logic [PIX_W-1:0]  mem [2][H_ACTIVE];

    logic              wr_bank;
    logic [ADDR_W-1:0] wr_ptr;
    logic              rd_full;

    logic              wr_bank_next;
    logic              rd_full_next;
    logic [ADDR_W-1:0] ptr_base;
    logic [ADDR_W-1:0] wr_ptr_next;
    logic              do_write;
    logic              underrun_set;
    logic              overflow_set;
    logic              rd_hit;
    logic              rd_bank;
    logic [PIX_W-1:0]  pixel;

    // Swap is applied before the write/read decisions of the same cycle.
    always_comb begin
        wr_bank_next = wr_bank;
        rd_full_next = rd_full;
        ptr_base     = wr_ptr;
        underrun_set = 1'b0;
        if (bus.line_swap) begin
            wr_bank_next = ~wr_bank;
            rd_full_next = (wr_ptr == LINE_END);
            ptr_base     = '0;
            underrun_set = (wr_ptr != LINE_END);
        end
        do_write     = bus.in_valid && (ptr_base < LINE_END);
        overflow_set = bus.in_valid && !do_write;
        wr_ptr_next  = do_write ? (ptr_base + ADDR_W'(1)) : ptr_base;
        rd_bank      = ~wr_bank_next;
        rd_hit       = bus.rd_visible && (bus.rd_x < LINE_END) && rd_full_next;
        pixel        = {bus.in_r, bus.in_g, bus.in_b};
    end

    // Line storage; contents deliberately not reset.
    always_ff @(posedge clk_25mhz) begin
        if (do_write) begin
            mem[wr_bank_next][ptr_base] <= pixel;
        end
    end

    // Bank bookkeeping and sticky error flags.
    always_ff @(posedge clk_25mhz or posedge rst) begin
        if (rst) begin
            wr_bank      <= 1'b0;
            wr_ptr       <= '0;
            rd_full      <= 1'b0;
            bus.underrun <= 1'b0;
            bus.overflow <= 1'b0;
        end else begin
            wr_bank <= wr_bank_next;
            wr_ptr  <= wr_ptr_next;
            rd_full <= rd_full_next;
            if (underrun_set) begin
                bus.underrun <= 1'b1;
            end
            if (overflow_set) begin
                bus.overflow <= 1'b1;
            end
        end
    end

    // Registered VGA colour; black outside the active range or without a full line.
    always_ff @(posedge clk_25mhz or posedge rst) begin
        if (rst) begin
            bus.out_r     <= '0;
            bus.out_g     <= '0;
            bus.out_b     <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.rd_visible;
            if (rd_hit) begin
                {bus.out_r, bus.out_g, bus.out_b} <= mem[rd_bank][bus.rd_x];
            end else begin
                bus.out_r <= '0;
                bus.out_g <= '0;
                bus.out_b <= '0;
            end
        end
    end
endmodule

// File: tb/tb_scanline_buffer.sv
// Directed bench for the scanline ping-pong buffer.
module tb_scanline_buffer;
    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned ADDR_W   = 10;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    scanline_buffer_if #(.ADDR_W(ADDR_W)) bus ();

    scanline_buffer #(.H_ACTIVE(H_ACTIVE), .ADDR_W(ADDR_W)) dut (
        .clk_25mhz (clk),
        .rst       (rst),
        .bus       (bus.slave)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Pixel pattern generator for the directed lines.
    function automatic logic [23:0] pat(input int mode, input int i);
        logic [7:0] b;
        b = 8'(i);
        case (mode)
            0:       return {b, ~b, 8'h5A};
            1:       return 24'h111111;
            2:       return 24'h222222;
            3:       return 24'h333333;
            4:       return 24'h400000 + 24'(i);
            5:       return 24'h555555;
            6:       return 24'h666666;
            default: return 24'h000000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] out_px();
        return {bus.out_r, bus.out_g, bus.out_b};
    endfunction

    task automatic write_pixels(input int n, input int mode, input int start);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            {bus.in_r, bus.in_g, bus.in_b} = pat(mode, start + i);
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic swap();
        bus.line_swap = 1'b1;
        tick();
        bus.line_swap = 1'b0;
    endtask

    task automatic sweep(input string tag, input int mode, input bit zero);
        for (int i = 0; i < int'(H_ACTIVE); i++) begin
            bus.rd_x       = ADDR_W'(i);
            bus.rd_visible = 1'b1;
            tick();
            chk(tag, 32'(out_px()), zero ? 32'h0 : 32'(pat(mode, i)));
        end
    endtask

    task automatic read_at(input string tag, input int x, input logic [23:0] exp);
        bus.rd_x       = ADDR_W'(x);
        bus.rd_visible = 1'b1;
        tick();
        chk(tag, 32'(out_px()), 32'(exp));
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'h1);
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_r       = '0;
        bus.in_g       = '0;
        bus.in_b       = '0;
        bus.line_swap  = 1'b0;
        bus.rd_x       = ADDR_W'(5);
        bus.rd_visible = 1'b1;

        // Reset holds outputs low regardless of read inputs.
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_out", 32'(out_px()), 32'h0);
            chk("rst_valid", 32'(bus.out_valid), 32'h0);
            chk("rst_underrun", 32'(bus.underrun), 32'h0);
            chk("rst_overflow", 32'(bus.overflow), 32'h0);
        end
        rst = 1'b0;
        tick();
        chk("post_rst_out", 32'(out_px()), 32'h0);
        chk("post_rst_valid", 32'(bus.out_valid), 32'h1);

        // Full-line round trip.
        write_pixels(H_ACTIVE, 0, 0);
        swap();
        sweep("roundtrip", 0, 1'b0);
        chk("roundtrip_underrun", 32'(bus.underrun), 32'h0);
        chk("roundtrip_overflow", 32'(bus.overflow), 32'h0);

        // Ping-pong: write B while line A is displayed.
        write_pixels(H_ACTIVE, 1, 0);
        swap();
        for (int i = 0; i < int'(H_ACTIVE); i++) begin
            bus.in_valid = 1'b1;
            {bus.in_r, bus.in_g, bus.in_b} = pat(2, i);
            bus.rd_x       = ADDR_W'(i);
            bus.rd_visible = 1'b1;
            tick();
            chk("pingpong_a", 32'(out_px()), 32'h111111);
        end
        bus.in_valid = 1'b0;
        swap();
        sweep("pingpong_b", 2, 1'b0);
        chk("pingpong_underrun", 32'(bus.underrun), 32'h0);

        // Underrun: short line reads back black and latches the flag.
        write_pixels(300, 3, 0);
        swap();
        chk("underrun_set", 32'(bus.underrun), 32'h1);
        sweep("underrun_black", 3, 1'b1);
        chk("underrun_sticky", 32'(bus.underrun), 32'h1);

        // Overflow: extra pixels dropped, last address keeps the 640th pixel.
        chk("overflow_clear", 32'(bus.overflow), 32'h0);
        write_pixels(645, 4, 0);
        chk("overflow_set", 32'(bus.overflow), 32'h1);
        swap();
        read_at("ovf_x639", 639, 24'h40027F);
        read_at("ovf_x0", 0, 24'h400000);
        read_at("oor_x700", 700, 24'h000000);
        bus.rd_x       = ADDR_W'(10);
        bus.rd_visible = 1'b0;
        tick();
        chk("invisible_out", 32'(out_px()), 32'h0);
        chk("invisible_valid", 32'(bus.out_valid), 32'h0);

        // Simultaneous write and swap; same-cycle read sees the completed line.
        write_pixels(H_ACTIVE, 5, 0);
        bus.in_valid   = 1'b1;
        {bus.in_r, bus.in_g, bus.in_b} = 24'hABCDEF;
        bus.line_swap  = 1'b1;
        bus.rd_x       = ADDR_W'(3);
        bus.rd_visible = 1'b1;
        tick();
        bus.line_swap  = 1'b0;
        bus.in_valid   = 1'b0;
        chk("swapwr_read_same_cycle", 32'(out_px()), 32'h555555);
        read_at("swapwr_prev_line", 639, 24'h555555);
        write_pixels(H_ACTIVE - 1, 6, 1);
        swap();
        read_at("swapwr_x0", 0, 24'hABCDEF);
        read_at("swapwr_x1", 1, 24'h666666);
        read_at("swapwr_x639", 639, 24'h666666);
        chk("flags_sticky_underrun", 32'(bus.underrun), 32'h1);
        chk("flags_sticky_overflow", 32'(bus.overflow), 32'h1);

        // Reset mid-line discards the partial line and clears the flags.
        write_pixels(100, 1, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_underrun", 32'(bus.underrun), 32'h0);
        chk("midrst_overflow", 32'(bus.overflow), 32'h0);
        read_at("midrst_black", 0, 24'h000000);
        write_pixels(50, 2, 0);
        swap();
        read_at("midrst_short_black", 0, 24'h000000);
        chk("midrst_short_underrun", 32'(bus.underrun), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/scanline_buffer.md
# scanline_buffer

Ping-pong line buffer between the quad-to-pixel serializer and the VGA colour outputs. It captures one scanline of serialized 24-bit pixels into a write bank while the VGA side reads the previously completed line from the other bank. This replaces the fixed pipeline-delay alignment with explicit per-line buffering. Output pixels are therefore address-aligned to `rd_x`, independent of shader or serializer latency.

## Interface
- `H_ACTIVE`, 640: pixels per line; also the depth of each bank.
- `ADDR_W`, 10: width of the write pointer and read address; must satisfy 2^ADDR_W > H_ACTIVE.
- `clk_25mhz` input 1: the single clock for the block.
- `rst` input 1: reset, asynchronous, active-high.
- `in_valid` input 1: a serialized pixel is present this cycle.
- `in_r`, `in_g`, `in_b` input 8 each: serialized pixel colour.
- `line_swap` input 1: single-cycle pulse at the start of each VGA line; swaps the banks.
- `rd_x` input ADDR_W: VGA horizontal pixel address.
- `rd_visible` input 1: VGA active-region flag.
- `out_r`, `out_g`, `out_b` output 8 each: registered pixel colour for the VGA pins.
- `out_valid` output 1: registered copy of `rd_visible`.
- `underrun` output 1: sticky; set when a line swaps with fewer than `H_ACTIVE` pixels written.
- `overflow` output 1: sticky; set when a pixel arrives after the write bank is full.

## Operation
- **Storage.** Two banks, each `H_ACTIVE` × 24 bits; `wr_bank` (1 bit) selects the write bank and `~wr_bank` is the read bank. RAM contents are not reset.
- **Write side.**
  - When `in_valid` is high and `wr_ptr < H_ACTIVE`, write `{in_r,in_g,in_b}` to `bank[wr_bank][wr_ptr]`, then increment `wr_ptr`.
  - When `in_valid` is high and `wr_ptr == H_ACTIVE`, drop the pixel, set `overflow`, and hold `wr_ptr`.
- **Swap.** On `line_swap`:
  - toggle `wr_bank`;
  - set `rd_full <= (wr_ptr == H_ACTIVE)`;
  - set `underrun` if `wr_ptr != H_ACTIVE`;
  - reset `wr_ptr` to 0.
- **Swap coinciding with a write.** If `in_valid` and `line_swap` are both high in the same cycle, the swap takes effect first: the pixel is written to address 0 of the new write bank, and `wr_ptr` becomes 1. The full/underrun evaluation uses the pre-swap `wr_ptr`.
- **Read side.** Each cycle, register:
  - `out_valid <= rd_visible`;
  - colour = `bank[~wr_bank_next][rd_x]` if `rd_visible && rd_x < H_ACTIVE && rd_full_next`, else 0.
  - Here "`_next`" means the value after any swap in the same cycle. A read issued together with `line_swap` therefore sees the just-completed line.
- **Blanking and addressing.** `rd_x >= H_ACTIVE` or `rd_full == 0` outputs black (0,0,0). No wrap-around on `rd_x`.
- **Sticky flags.** `underrun` and `overflow` clear only on `rst`.
- **Reset values.**
  - `out_r`/`out_g`/`out_b` = 0, `out_valid` = 0, `underrun` = 0, `overflow` = 0.
  - Internal: `wr_bank` = 0, `wr_ptr` = 0, `rd_full` = 0.
- **Reset during a line.** Asserting `rst` mid-line discards the partial line. Output stays black until one full line has been written and swapped.

## Timing
- **Read latency.** 1 cycle: `rd_x`/`rd_visible` at cycle N produce `out_*`/`out_valid` at cycle N+1. The VGA controller's `hsync`/`vsync` must be delayed by one register in the top level to stay aligned.
- **Write rate.** At most 1 pixel per cycle; there is no backpressure and no ready signal.
- **Line delay.** A line written between swap k and swap k+1 is displayed during the VGA line that follows swap k+1. Total display delay is therefore one line plus one cycle.
- **Swap pulse.** `line_swap` must be a single-cycle pulse. A pulse held high for n cycles performs n swaps, and each extra swap flags `underrun` because the write pointer is 0.
- **Worst-case fill time.** A full line needs `H_ACTIVE` cycles of `in_valid`, which fits inside an 800-cycle VGA line at 25 MHz.

## Test plan
- **Reset behaviour.** Assert `rst` with `rd_visible=1`, `rd_x=5` → `out_*=0` and `out_valid=0` in every cycle. After release, with no completed line, `out_*=0` and `out_valid=1`.
- **Full-line round trip.** Write 640 pixels where pixel i = (i[7:0], ~i[7:0], 0x5A), then pulse `line_swap`. Sweep `rd_x` 0..639 with `rd_visible=1` → one cycle later `out` = (rd_x[7:0], ~rd_x[7:0], 0x5A) for every address; `underrun=0`.
- **Ping-pong overlap.** Write line A (all 0x11), swap, then write line B (all 0x22) while reading line A → reads return 0x111111 throughout. After the next swap, reads return 0x222222.
- **Underrun.** Write 300 pixels, then swap → `underrun=1` stays latched, and reads of the next line return 0 at every `rd_x`.
- **Overflow and out-of-range read.** Write 645 pixels → `overflow=1` and address 639 holds the 640th pixel. Reading `rd_x=700` with `rd_visible=1` → `out=0` and `out_valid=1`.
- **Simultaneous write and swap.** `in_valid` with value 0xABCDEF in the same cycle as `line_swap` → after the next swap, `rd_x=0` returns 0xABCDEF. The pre-swap pointer determines `rd_full` for the bank just completed.
